// File: rtl/tmds_encoder_pipe_if.sv
// Bundles the pixel-side inputs and serializer-side outputs of the TMDS encoder.
interface tmds_encoder_pipe_if #(
  parameter int NUM_CH = 3
);
  logic                   in_valid;
  logic [1:0]             in_mode;
  logic [NUM_CH*8-1:0]    in_data;
  logic [NUM_CH*2-1:0]    in_ctrl;
  logic                   out_valid;
  logic [NUM_CH*10-1:0]   tmds_out;
  logic                   mode_err;

  modport master (
    output in_valid, in_mode, in_data, in_ctrl,
    input  out_valid, tmds_out, mode_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_ctrl,
    output out_valid, tmds_out, mode_err
  );
endinterface

// File: rtl/tmds_encoder_pipe.sv
// Three-stage multi-lane TMDS encoder: transition minimisation, popcount, then
// DC balancing against a per-lane running disparity, plus control/guard codes.
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3,
  parameter int DISP_W = 5
) (
  input logic pix_clk,
  input logic rst,
  tmds_encoder_pipe_if.slave bus
);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < 8; k++) c = c + {3'b000, v[k]};
    return c;
  endfunction

  function automatic logic [8:0] calc_qm(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int k = 1; k < 8; k++) q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  logic                     v1, v2;
  logic [1:0]               mode1, mode2;
  logic [NUM_CH*2-1:0]      ctrl1, ctrl2;
  logic [8:0]               qm_c [NUM_CH];
  logic [8:0]               qm1  [NUM_CH];
  logic [8:0]               qm2  [NUM_CH];
  logic [3:0]               n1_2 [NUM_CH];
  logic [9:0]               sym  [NUM_CH];
  logic [9:0]               sym_n [NUM_CH];
  logic signed [DISP_W-1:0] disp   [NUM_CH];
  logic signed [DISP_W-1:0] disp_n [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) qm_c[i] = calc_qm(bus.in_data[8*i +: 8]);
  end

  // Each stage only loads when its incoming valid is high, so bubbles leave data untouched.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      mode1         <= '0;
      mode2         <= '0;
      ctrl1         <= '0;
      ctrl2         <= '0;
      bus.out_valid <= 1'b0;
      bus.mode_err  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        qm1[i]  <= '0;
        qm2[i]  <= '0;
        n1_2[i] <= '0;
        sym[i]  <= '0;
        disp[i] <= '0;
      end
    end else begin
      v1            <= bus.in_valid;
      v2            <= v1;
      bus.out_valid <= v2;
      bus.mode_err  <= v2 && (mode2 == 2'b11);
      if (bus.in_valid) begin
        mode1 <= bus.in_mode;
        ctrl1 <= bus.in_ctrl;
        for (int i = 0; i < NUM_CH; i++) qm1[i] <= qm_c[i];
      end
      if (v1) begin
        mode2 <= mode1;
        ctrl2 <= ctrl1;
        for (int i = 0; i < NUM_CH; i++) begin
          qm2[i]  <= qm1[i];
          n1_2[i] <= ones8(qm1[i][7:0]);
        end
      end
      if (v2) begin
        for (int i = 0; i < NUM_CH; i++) begin
          sym[i]  <= sym_n[i];
          disp[i] <= disp_n[i];
        end
      end
    end
  end

  // diff holds n1-n0 = 2*n1-8; the sign bit of disp doubles as the cnt<0 test.
  always_comb begin
    logic signed [DISP_W-1:0] diff;
    logic [8:0]               q;
    logic [1:0]               c;
    for (int i = 0; i < NUM_CH; i++) begin
      q         = qm2[i];
      c         = ctrl2[2*i +: 2];
      diff      = (DISP_W'(n1_2[i]) <<< 1) - DISP_W'(8);
      sym_n[i]  = '0;
      disp_n[i] = '0;
      case (mode2)
        2'b01: begin
          if ((disp[i] == '0) || (n1_2[i] == 4'd4)) begin
            sym_n[i]  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            disp_n[i] = q[8] ? (disp[i] + diff) : (disp[i] - diff);
          end else if ((!disp[i][DISP_W-1] && (n1_2[i] > 4'd4)) ||
                       (disp[i][DISP_W-1] && (n1_2[i] < 4'd4))) begin
            sym_n[i]  = {1'b1, q[8], ~q[7:0]};
            disp_n[i] = disp[i] + (q[8] ? DISP_W'(2) : DISP_W'(0)) - diff;
          end else begin
            sym_n[i]  = {1'b0, q[8], q[7:0]};
            disp_n[i] = disp[i] - (q[8] ? DISP_W'(0) : DISP_W'(2)) + diff;
          end
        end
        2'b10: sym_n[i] = (i % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
        default: begin
          case (c)
            2'b00:   sym_n[i] = 10'b1101010100;
            2'b01:   sym_n[i] = 10'b0010101011;
            2'b10:   sym_n[i] = 10'b0101010100;
            default: sym_n[i] = 10'b1010101011;
          endcase
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign bus.tmds_out[10*g +: 10] = sym[g];
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Randomised scoreboard bench for tmds_encoder_pipe against an integer-arithmetic model.
module tb_tmds_encoder_pipe;
  localparam int NUM_CH = 3;
  localparam int DISP_W = 5;

  typedef struct {
    logic [NUM_CH*10-1:0] tmds;
    logic                 err;
  } exp_t;

  logic pix_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cnt [NUM_CH];
  int   lowRun  = 0;
  int   lastGap = -1;
  logic [NUM_CH*10-1:0] lastTmds = '0;
  exp_t expQ [$];

  tmds_encoder_pipe_if #(.NUM_CH(NUM_CH)) bus ();

  tmds_encoder_pipe #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 pix_clk = ~pix_clk;

  function automatic exp_t modelWord(input logic [1:0] m, input logic [NUM_CH*8-1:0] d,
                                     input logic [NUM_CH*2-1:0] c);
    exp_t e;
    logic [9:0] codes [4];
    codes[0] = 10'b1101010100;
    codes[1] = 10'b0010101011;
    codes[2] = 10'b0101010100;
    codes[3] = 10'b1010101011;
    e.tmds = '0;
    e.err  = (m == 2'b11);
    for (int i = 0; i < NUM_CH; i++) begin
      logic [7:0] b, q;
      logic [9:0] s;
      int n1d, n1, n0, q8;
      bit xn;
      b = d[8*i +: 8];
      if (m == 2'b01) begin
        n1d = $countones(b);
        xn  = (n1d > 4) || (n1d == 4 && b[0] == 1'b0);
        q[0] = b[0];
        for (int k = 1; k < 8; k++) q[k] = xn ? ~(q[k-1] ^ b[k]) : (q[k-1] ^ b[k]);
        q8 = xn ? 0 : 1;
        n1 = $countones(q);
        n0 = 8 - n1;
        if (cnt[i] == 0 || n1 == n0) begin
          s = {q8 ? 2'b01 : 2'b10, q8 ? q : ~q};
          cnt[i] += q8 ? (n1 - n0) : (n0 - n1);
        end else if ((cnt[i] > 0 && n1 > n0) || (cnt[i] < 0 && n0 > n1)) begin
          s = {1'b1, q8[0], ~q};
          cnt[i] += 2 * q8 + (n0 - n1);
        end else begin
          s = {1'b0, q8[0], q};
          cnt[i] += -2 * (1 - q8) + (n1 - n0);
        end
      end else if (m == 2'b10) begin
        s = (i % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
        cnt[i] = 0;
      end else begin
        s = codes[c[2*i +: 2]];
        cnt[i] = 0;
      end
      e.tmds[10*i +: 10] = s;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] m,
                               input logic [NUM_CH*8-1:0] d, input logic [NUM_CH*2-1:0] c);
    @(posedge pix_clk);
    #1;
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    if (v) expQ.push_back(modelWord(m, d, c));
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b00, '0, '0);
  endtask

  // Monitor: pops the scoreboard on every valid output, checks hold behaviour otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge pix_clk);
      if (rst) begin
        lastTmds = '0;
        lowRun   = 0;
      end else if (bus.out_valid) begin
        lastGap = lowRun;
        lowRun  = 0;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", 64'(bus.tmds_out), 64'hDEAD);
        end else begin
          e = expQ.pop_front();
          checkOutput("tmds_symbol", 64'(bus.tmds_out), 64'(e.tmds));
          checkOutput("mode_err", 64'(bus.mode_err), 64'(e.err));
        end
        lastTmds = bus.tmds_out;
      end else begin
        lowRun++;
        checkOutput("hold_tmds", 64'(bus.tmds_out), 64'(lastTmds));
        checkOutput("idle_mode_err", 64'(bus.mode_err), 64'd0);
      end
    end
  end

  initial begin
    logic [1:0] m;
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    bus.in_valid = 1'b0;
    bus.in_mode  = 2'b00;
    bus.in_data  = '0;
    bus.in_ctrl  = '0;
    #23;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_tmds", 64'(bus.tmds_out), 64'd0);
    checkOutput("reset_mode_err", 64'(bus.mode_err), 64'd0);
    #4 rst = 1'b0;

    $display("[TB] control word, lane0 ctrl=01");
    applyStimulus(1'b1, 2'b00, 24'h0, 6'b00_00_01);
    idle(4);
    checkOutput("ctrl_lane0", 64'(lastTmds[9:0]), 64'(10'b0010101011));
    checkOutput("ctrl_lane1", 64'(lastTmds[19:10]), 64'(10'b1101010100));

    $display("[TB] repeated zero video");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 2'b01, 24'h000000, '0);
    checkOutput("model_cnt_bound", 64'((cnt[0] <= 10 && cnt[0] >= -10)), 64'd1);

    $display("[TB] 1000 words of FF");
    for (int k = 0; k < 1000; k++) applyStimulus(1'b1, 2'b01, 24'hFFFFFF, '0);

    $display("[TB] bubble of 5 cycles");
    applyStimulus(1'b1, 2'b01, 24'h101010, '0);
    idle(5);
    applyStimulus(1'b1, 2'b01, 24'h101010, '0);
    idle(4);
    checkOutput("bubble_gap", 64'(lastGap), 64'd5);

    $display("[TB] guard band then video");
    applyStimulus(1'b1, 2'b10, 24'h0, '0);
    applyStimulus(1'b1, 2'b01, 24'h5A3C01, '0);
    idle(4);

    $display("[TB] randomised traffic");
    for (int k = 0; k < 400; k++) begin
      m = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 9) < 8), m, 24'($urandom), 6'($urandom));
    end
    idle(5);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] reset with two words in flight");
    applyStimulus(1'b1, 2'b01, 24'h123456, '0);
    applyStimulus(1'b1, 2'b01, 24'hABCDEF, '0);
    @(posedge pix_clk);
    #1 bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    expQ.delete();
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    #1;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_tmds", 64'(bus.tmds_out), 64'd0);
    checkOutput("rst_mode_err", 64'(bus.mode_err), 64'd0);
    @(posedge pix_clk);
    @(posedge pix_clk);
    #2 rst = 1'b0;
    idle(3);
    applyStimulus(1'b1, 2'b11, 24'h0, 6'b11_10_01);
    applyStimulus(1'b1, 2'b01, 24'h00FF80, '0);
    idle(5);
    checkOutput("final_queue_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
